memory_access: RTL and testbench
================================

# memory_access

Memory (M) stage of the in-order RV32IM pipeline, directly downstream of the execution stage. It captures the execution stage's memory command (`minst`), effective address and store data. It runs one load/store per instruction over a req/gnt/rvalid data-memory port, aligns and sign-extends load data, and presents the register writeback for both loads and pass-through ALU results. While a memory access is outstanding it stalls the pipeline.

## Interface
Parameters: none.

- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `minst` in 4: memory command from execution. `{0,funct3}` = load, `{1,funct3}` = store, `minst[3:2]==2'b11` = no memory op.
- `rdm_v` in 1: instruction writes `rd` through this stage.
- `rd` in 5: destination register.
- `rd_data` in 32: ALU result. This is the effective address for loads and stores.
- `rs2_data` in 32: store data.
- `mem_stall` out 1: stage busy; upstream holds all inputs while high.
- `dmem_req` out 1: bus request.
- `dmem_we` out 1: 1 = store.
- `dmem_addr` out 32: word address, bits [1:0] always 0.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_gnt` in 1: request accepted this cycle.
- `dmem_rvalid` in 1: load data valid.
- `dmem_rdata` in 32: load data word.
- `wb_v` out 1: writeback valid.
- `wb_rd` out 5: writeback register.
- `wb_data` out 32: writeback data.
- `mem_err` out 1: one-cycle pulse for a misaligned or illegal-funct3 memory op.

## Operation
- **Capture (M registers).** On each edge with `mem_stall==0`, the stage registers `minst`, `rdm_v`, `rd`, `rd_data`, `rs2_data` and `m_valid`.
  - `m_valid = (minst[3:2]!=2'b11) | rdm_v`.
  - With `mem_stall==1`, the registers hold.
- **Classification at capture.**
  - Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal stores: 000 SB, 001 SH, 010 SW.
  - Misaligned: H with `addr[0]`=1; W with `addr[1:0]`≠0.
  - Illegal or misaligned op: the next state stays IDLE, `mem_err`=1 for the cycle after capture, no bus access, no writeback.
- **FSM states:** IDLE, REQ, RESP.
  - IDLE → REQ: on capture of a legal, aligned memory op.
  - REQ: `dmem_req`=1.
    - `dmem_gnt` with a store → IDLE.
    - `dmem_gnt` with a load → RESP.
    - Otherwise stay in REQ.
  - RESP: `dmem_rvalid` → IDLE; otherwise stay in RESP.
- **Stall.** `mem_stall = (REQ & !(dmem_gnt & store)) | (RESP & !dmem_rvalid)`.
  - A completing cycle does not stall, so the next instruction is captured at that same edge (back-to-back issue).
- **Store lanes** (`a` = `addr[1:0]`):
  - SB: `be = 4'b0001<<a`, `wdata = {4{rs2[7:0]}}`.
  - SH: `be = 4'b0011<<a`, `wdata = {2{rs2[15:0]}}`.
  - SW: `be = 4'b1111`, `wdata = rs2`.
  - Loads drive `be = 4'b1111`, `dmem_we = 0`.
- **Load extract:**
  - Byte: `dmem_rdata[8a+7:8a]`.
  - Half: `[16·a[1]+15:16·a[1]]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- **Writeback:**
  - Non-memory op with `rdm_v`: `wb_v`=1 for the single cycle after capture, `wb_data` = captured `rd_data`.
  - Load: `wb_v = RESP & dmem_rvalid & rdm_v`, `wb_data` = extracted value.
  - Stores never write back.
  - `wb_rd` = captured `rd`.

## Timing
- **Reset** (asynchronous assert, synchronous-to-clk deassert use):
  - State → IDLE; all M registers → 0.
  - All outputs read 0: `mem_stall`, `dmem_req`, `dmem_we`, `dmem_be`, `dmem_addr`, `dmem_wdata`, `wb_v`, `wb_rd`, `wb_data`, `mem_err`.
- **Reset mid-operation.** An outstanding `dmem_gnt` or `dmem_rvalid` arriving after reset is ignored. No writeback occurs.
- **Bus outputs** are combinational from the M registers and state. They stay stable through REQ until `dmem_gnt`.
- **Latencies:**
  - ALU pass-through: `wb_v` 1 cycle after capture.
  - Store: minimum 1 cycle (`gnt` in the first REQ cycle), no stall.
  - Load: minimum 2 cycles (gnt, then rvalid next cycle). `mem_stall` is high during the first REQ cycle and low in the rvalid cycle.
- **Bus rules:**
  - `dmem_rvalid` is accepted only in RESP. In IDLE or REQ it is ignored.
  - `dmem_gnt` is accepted only in REQ.
- **`mem_err`:** exactly one cycle, never concurrent with `dmem_req` for the same instruction.

## Test plan
- **Reset outputs:** assert `reset`=0 mid-load in RESP, then release → all outputs 0, state IDLE. A late `dmem_rvalid` produces no `wb_v`.
- **ALU pass-through:** capture `rdm_v`=1, `rd`=5, `rd_data`=0x1234, `minst`=4'b1100 → next cycle `wb_v`=1, `wb_rd`=5, `wb_data`=0x1234, `mem_stall`=0.
- **Store SB:** SB, addr 0x103, `rs2`=0xAABBCC7F, `gnt` after 2 wait cycles → `dmem_addr`=0x100, `be`=4'b1000, `wdata`=0x7F7F7F7F, `mem_stall` high 2 cycles, `wb_v` never set.
- **LB / LHU extract:** LB at 0x2 with `rdata`=0x00800000 → `wb_data`=0xFFFFFF80. LHU at 0x2 with `rdata`=0x80010000 → 0x00008001.
- **Misaligned:** LW at 0x6 → `mem_err` pulse 1 cycle, `dmem_req` stays 0, no `wb_v`. SH at 0x1 → same response.
- **Back-to-back:** LW then SW with `gnt` immediate and `rvalid` next cycle → the SW `dmem_req` rises in the cycle after the LW rvalid/`wb_v` cycle, with no bubble beyond the FSM.

Source files
------------

// File: rtl/memory_access_if.sv
// Data-memory port of the M stage: request/grant for the command phase and
// rvalid for load data returning in a later cycle.
interface memory_access_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/memory_access.sv
// M stage of the RV32IM pipeline: issues one load/store per instruction,
// aligns load data and presents the register writeback for loads and ALU ops.
module memory_access (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      minst,
    input  logic            rdm_v,
    input  logic [4:0]      rd,
    input  logic [31:0]     rd_data,
    input  logic [31:0]     rs2_data,
    output logic            mem_stall,
    memory_access_if.master dmem,
    output logic            wb_v,
    output logic [4:0]      wb_rd,
    output logic [31:0]     wb_data,
    output logic            mem_err
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state_reg;
    logic [3:0]  minst_reg;
    logic        rdm_v_reg;
    logic [4:0]  rd_reg;
    logic [31:0] addr_reg;
    logic [31:0] rs2_reg;
    logic        m_valid_reg;
    logic        err_reg;

    // Decode of the incoming command, used only at the capture edge.
    logic       is_mem_in;
    logic [2:0] f3_in;
    logic       legal_in;
    logic       misalign_in;
    logic       ok_in;

    always_comb begin
        is_mem_in = (minst[3:2] != 2'b11);
        f3_in     = minst[2:0];
        legal_in  = is_mem_in &&
                    ((f3_in == 3'b000) || (f3_in == 3'b001) || (f3_in == 3'b010) ||
                     (!minst[3] && ((f3_in == 3'b100) || (f3_in == 3'b101))));
        misalign_in = ((f3_in[1:0] == 2'b01) && rd_data[0]) ||
                      ((f3_in[1:0] == 2'b10) && (rd_data[1:0] != 2'b00));
        ok_in = legal_in && !misalign_in;
    end

    logic       is_store;
    logic [2:0] f3;
    logic [1:0] lane;
    logic       in_req;
    logic       in_resp;

    assign is_store = minst_reg[3];
    assign f3       = minst_reg[2:0];
    assign lane     = addr_reg[1:0];
    assign in_req   = (state_reg == REQ);
    assign in_resp  = (state_reg == RESP);

    // A completing store or load does not stall, so the next command is
    // captured on the same edge that retires this one.
    assign mem_stall = (in_req && !(dmem.gnt && is_store)) ||
                       (in_resp && !dmem.rvalid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            minst_reg   <= 4'd0;
            rdm_v_reg   <= 1'b0;
            rd_reg      <= 5'd0;
            addr_reg    <= 32'd0;
            rs2_reg     <= 32'd0;
            m_valid_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else if (!mem_stall) begin
            minst_reg   <= minst;
            rdm_v_reg   <= rdm_v;
            rd_reg      <= rd;
            addr_reg    <= rd_data;
            rs2_reg     <= rs2_data;
            m_valid_reg <= is_mem_in || rdm_v;
            err_reg     <= is_mem_in && !ok_in;
            state_reg   <= ok_in ? REQ : IDLE;
        end else begin
            err_reg <= 1'b0;
            if (in_req && dmem.gnt) begin
                state_reg <= RESP;
            end
        end
    end

    // Bus command is held stable for the whole REQ phase and zero otherwise.
    logic [3:0]  be_raw;
    logic [31:0] wdata_raw;

    always_comb begin
        be_raw    = 4'b1111;
        wdata_raw = rs2_reg;
        if (is_store) begin
            case (f3[1:0])
                2'b00: begin
                    be_raw    = 4'b0001 << lane;
                    wdata_raw = {4{rs2_reg[7:0]}};
                end
                2'b01: begin
                    be_raw    = 4'b0011 << lane;
                    wdata_raw = {2{rs2_reg[15:0]}};
                end
                default: begin
                    be_raw    = 4'b1111;
                    wdata_raw = rs2_reg;
                end
            endcase
        end
    end

    assign dmem.req   = in_req;
    assign dmem.we    = in_req && is_store;
    assign dmem.addr  = in_req ? {addr_reg[31:2], 2'b00} : 32'd0;
    assign dmem.be    = in_req ? be_raw : 4'd0;
    assign dmem.wdata = (in_req && is_store) ? wdata_raw : 32'd0;

    logic [7:0] rbyte [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rbyte[gi] = dmem.rdata[8*gi +: 8];
        end
    endgenerate

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;

    always_comb begin
        sel_byte = rbyte[lane];
        sel_half = lane[1] ? {rbyte[3], rbyte[2]} : {rbyte[1], rbyte[0]};
        case (f3)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_data = {24'd0, sel_byte};
            3'b101:  load_data = {16'd0, sel_half};
            default: load_data = dmem.rdata;
        endcase
    end

    // A non-memory op sits in IDLE for exactly one cycle after capture, so
    // its writeback is naturally a single-cycle pulse.
    logic alu_wb;
    logic load_done;

    assign alu_wb    = m_valid_reg && rdm_v_reg && (minst_reg[3:2] == 2'b11);
    assign load_done = in_resp && dmem.rvalid;

    assign wb_v    = alu_wb || (load_done && rdm_v_reg);
    assign wb_rd   = rd_reg;
    assign wb_data = load_done ? load_data : (alu_wb ? addr_reg : 32'd0);
    assign mem_err = err_reg;
endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: stimulus pushes expected bus, writeback
// and error events; a negedge monitor pops and compares what the DUT shows.
module tb_memory_access;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  minst;
    logic        rdm_v;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic [31:0] rs2_data;
    logic        mem_stall;
    logic        wb_v;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_err;

    always #5 clk = ~clk;

    memory_access_if dmem ();

    memory_access dut (
        .clk      (clk),
        .reset    (reset),
        .minst    (minst),
        .rdm_v    (rdm_v),
        .rd       (rd),
        .rd_data  (rd_data),
        .rs2_data (rs2_data),
        .mem_stall(mem_stall),
        .dmem     (dmem),
        .wb_v     (wb_v),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .mem_err  (mem_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    bus_t bus_q[$];
    wb_t  wb_q[$];
    int   err_q[$];
    bus_t bexp;
    wb_t  wexp;
    int   etag;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Memory model: grant after gnt_wait REQ cycles, data rv_wait cycles after RESP starts.
    int          gnt_wait  = 0;
    int          rv_wait   = 0;
    logic [31:0] load_word = 32'd0;
    int          req_cnt   = 0;
    int          resp_cnt  = 0;
    bit          pend      = 1'b0;

    initial begin
        dmem.gnt    = 1'b0;
        dmem.rvalid = 1'b0;
        dmem.rdata  = 32'd0;
    end

    always @(negedge clk) begin
        dmem.gnt    = 1'b0;
        dmem.rvalid = 1'b0;
        dmem.rdata  = 32'd0;
        if (pend) begin
            if (resp_cnt >= rv_wait) begin
                dmem.rvalid = 1'b1;
                dmem.rdata  = load_word;
                pend        = 1'b0;
            end else begin
                resp_cnt++;
            end
        end else if (dmem.req) begin
            if (req_cnt >= gnt_wait) begin
                dmem.gnt = 1'b1;
                req_cnt  = 0;
                if (!dmem.we) begin
                    pend     = 1'b1;
                    resp_cnt = 0;
                end
            end else begin
                req_cnt++;
            end
        end
    end

    int   cyc           = 0;
    int   wb_seen       = 0;
    int   stall_cycles  = 0;
    int   last_wb_cyc   = -1;
    int   last_req_rise = -1;
    logic req_prev      = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        #2;
        if (reset) begin
            if (mem_stall) stall_cycles++;
            if (dmem.req && !req_prev) last_req_rise = cyc;
            req_prev = dmem.req;

            if (dmem.req && dmem.gnt) begin
                if (bus_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_bus: got we=%0b addr=0x%08h be=%b expected none",
                             dmem.we, dmem.addr, dmem.be);
                end else begin
                    bexp = bus_q.pop_front();
                    check("bus_we", 32'(dmem.we), 32'(bexp.we));
                    check("bus_addr", dmem.addr, bexp.addr);
                    check("bus_be", 32'(dmem.be), 32'(bexp.be));
                    if (bexp.we) check("bus_wdata", dmem.wdata, bexp.wdata);
                end
            end

            if (wb_v) begin
                wb_seen++;
                last_wb_cyc = cyc;
                if (wb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_wb: got rd=%0d data=0x%08h expected none", wb_rd, wb_data);
                end else begin
                    wexp = wb_q.pop_front();
                    check("wb_rd", 32'(wb_rd), 32'(wexp.rd));
                    check("wb_data", wb_data, wexp.data);
                    check("wb_no_stall", 32'(mem_stall), 32'd0);
                end
            end

            if (mem_err) begin
                if (err_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_err: got mem_err=1 expected 0");
                end else begin
                    etag = err_q.pop_front();
                    check("err_no_req", 32'(dmem.req), 32'd0);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] mi, input logic v, input logic [4:0] r,
                         input logic [31:0] a, input logic [31:0] s);
        int k;
        @(negedge clk);
        #1;
        minst = mi; rdm_v = v; rd = r; rd_data = a; rs2_data = s;
        k = 0;
        while (mem_stall && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 100) begin
            n_total++;
            $display("FAIL issue_timeout: got mem_stall=1 for %0d cycles expected release", k);
        end
        @(posedge clk);
        #1;
        minst = 4'b1100; rdm_v = 1'b0; rd = 5'd0; rd_data = 32'd0; rs2_data = 32'd0;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) issue(4'b1100, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic exp_bus(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        bus_t e;
        e.we = we; e.addr = a; e.be = be; e.wdata = wd;
        bus_q.push_back(e);
    endtask

    task automatic exp_wb(input logic [4:0] r, input logic [31:0] d);
        wb_t e;
        e.rd = r; e.data = d;
        wb_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, 32'(mem_stall), 32'd0);
        check({tag, "_req"}, 32'(dmem.req), 32'd0);
        check({tag, "_we"}, 32'(dmem.we), 32'd0);
        check({tag, "_be"}, 32'(dmem.be), 32'd0);
        check({tag, "_addr"}, dmem.addr, 32'd0);
        check({tag, "_wdata"}, dmem.wdata, 32'd0);
        check({tag, "_wb_v"}, 32'(wb_v), 32'd0);
        check({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
        check({tag, "_wb_data"}, wb_data, 32'd0);
        check({tag, "_mem_err"}, 32'(mem_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    int s0;
    int w0;

    initial begin
        reset = 1'b0;
        minst = 4'b1100; rdm_v = 1'b0; rd = 5'd0; rd_data = 32'd0; rs2_data = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);

        // ALU pass-through
        exp_wb(5'd5, 32'h0000_1234);
        issue(4'b1100, 1'b1, 5'd5, 32'h0000_1234, 32'd0);
        @(negedge clk);
        #3;
        check("alu_wb_latency", 32'(wb_v), 32'd1);
        nop(2);

        // SB at 0x103 with two grant wait cycles; rdm_v set but stores never write back
        gnt_wait = 2;
        s0 = stall_cycles;
        exp_bus(1'b1, 32'h0000_0100, 4'b1000, 32'h7F7F_7F7F);
        issue(4'b1000, 1'b1, 5'd9, 32'h0000_0103, 32'hAABB_CC7F);
        nop(4);
        check("sb_stall_cycles", 32'(stall_cycles - s0), 32'd2);
        gnt_wait = 0;

        // LB at 0x2: byte 0x80 sign-extends
        load_word = 32'h0080_0000;
        exp_bus(1'b0, 32'h0000_0000, 4'b1111, 32'd0);
        exp_wb(5'd6, 32'hFFFF_FF80);
        issue(4'b0000, 1'b1, 5'd6, 32'h0000_0002, 32'd0);
        nop(3);

        // LHU at 0x2: upper half zero-extends; minimum load stall is one cycle
        load_word = 32'h8001_0000;
        s0 = stall_cycles;
        exp_bus(1'b0, 32'h0000_0000, 4'b1111, 32'd0);
        exp_wb(5'd7, 32'h0000_8001);
        issue(4'b0101, 1'b1, 5'd7, 32'h0000_0002, 32'd0);
        nop(3);
        check("load_stall_cycles", 32'(stall_cycles - s0), 32'd1);

        // LH at 0x0: lower half sign-extends
        load_word = 32'h1234_F00D;
        exp_bus(1'b0, 32'h0000_0000, 4'b1111, 32'd0);
        exp_wb(5'd8, 32'hFFFF_F00D);
        issue(4'b0001, 1'b1, 5'd8, 32'h0000_0000, 32'd0);
        nop(3);

        // LBU at 0x1 with slow grant and slow data
        gnt_wait  = 1;
        rv_wait   = 2;
        load_word = 32'h0000_AB00;
        exp_bus(1'b0, 32'h0000_0000, 4'b1111, 32'd0);
        exp_wb(5'd9, 32'h0000_00AB);
        issue(4'b0100, 1'b1, 5'd9, 32'h0000_0001, 32'd0);
        nop(6);
        gnt_wait = 0;
        rv_wait  = 0;

        // LW at 0x8
        load_word = 32'hDEAD_BEEF;
        exp_bus(1'b0, 32'h0000_0008, 4'b1111, 32'd0);
        exp_wb(5'd10, 32'hDEAD_BEEF);
        issue(4'b0010, 1'b1, 5'd10, 32'h0000_0008, 32'd0);
        nop(3);

        // SH at 0x102 and SW at 0x20
        exp_bus(1'b1, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD);
        issue(4'b1001, 1'b0, 5'd0, 32'h0000_0102, 32'h1234_ABCD);
        exp_bus(1'b1, 32'h0000_0020, 4'b1111, 32'hCAFE_F00D);
        issue(4'b1010, 1'b0, 5'd0, 32'h0000_0020, 32'hCAFE_F00D);
        nop(2);

        // LW without rdm_v: bus access, no writeback
        load_word = 32'h0BAD_0BAD;
        exp_bus(1'b0, 32'h0000_0004, 4'b1111, 32'd0);
        issue(4'b0010, 1'b0, 5'd11, 32'h0000_0004, 32'd0);
        nop(3);

        // Misaligned LW at 0x6: one-cycle error, no bus, no writeback
        err_q.push_back(1);
        issue(4'b0010, 1'b1, 5'd11, 32'h0000_0006, 32'd0);
        @(negedge clk);
        #3;
        check("lw_mis_err", 32'(mem_err), 32'd1);
        @(negedge clk);
        #3;
        check("lw_mis_err_clear", 32'(mem_err), 32'd0);

        // Misaligned SH at 0x1
        err_q.push_back(2);
        issue(4'b1001, 1'b0, 5'd0, 32'h0000_0001, 32'h5555_5555);
        @(negedge clk);
        #3;
        check("sh_mis_err", 32'(mem_err), 32'd1);
        nop(2);

        // Illegal load funct3 011
        err_q.push_back(3);
        issue(4'b0011, 1'b1, 5'd12, 32'h0000_0000, 32'd0);
        nop(2);

        // Back-to-back LW then SW
        load_word = 32'h55AA_00FF;
        exp_bus(1'b0, 32'h0000_0040, 4'b1111, 32'd0);
        exp_wb(5'd12, 32'h55AA_00FF);
        exp_bus(1'b1, 32'h0000_0044, 4'b1111, 32'h0102_0304);
        issue(4'b0010, 1'b1, 5'd12, 32'h0000_0040, 32'd0);
        issue(4'b1010, 1'b0, 5'd0, 32'h0000_0044, 32'h0102_0304);
        nop(3);
        check("b2b_req_after_wb", 32'(last_req_rise - last_wb_cyc), 32'd1);

        // Reset while a load waits in RESP; the late rvalid must be ignored
        rv_wait   = 4;
        load_word = 32'h1111_1111;
        w0 = wb_seen;
        exp_bus(1'b0, 32'h0000_0010, 4'b1111, 32'd0);
        issue(4'b0010, 1'b1, 5'd13, 32'h0000_0010, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        reset = 1'b1;
        nop(8);
        check("rst_no_wb", 32'(wb_seen - w0), 32'd0);
        check("rst_idle_no_stall", 32'(mem_stall), 32'd0);
        rv_wait = 0;

        check("bus_q_empty", 32'(bus_q.size()), 32'd0);
        check("wb_q_empty", 32'(wb_q.size()), 32'd0);
        check("err_q_empty", 32'(err_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
